// File: rtl/gpio_bank.sv
// GPIO bank: per-channel IN / OUT / IRQ_MASK / EDGE registers on an
// Avalon-MM slave, with double-synchronised pins and sticky edge capture.
module gpio_bank #(
   parameter int CHANNELS  = 4,
   parameter int WIDTH     = 32,
   parameter int EDGE_MODE = 0
) (
   input  logic                      clk_clk,
   input  logic                      reset_reset_n,
   input  logic [4:0]                avs_address,
   input  logic                      avs_read,
   input  logic                      avs_write,
   input  logic [31:0]               avs_writedata,
   output logic [31:0]               avs_readdata,
   input  logic [CHANNELS*WIDTH-1:0] gpio_in_port,
   output logic [CHANNELS*WIDTH-1:0] gpio_out_port,
   output logic                      irq
);

   localparam int BITS = CHANNELS * WIDTH;

   logic [BITS-1:0]  sync1_q, sync1_d;
   logic [BITS-1:0]  sync2_q, sync2_d;
   logic [BITS-1:0]  prev_q, prev_d;
   logic [BITS-1:0]  out_q, out_d;
   logic [BITS-1:0]  mask_q, mask_d;
   logic [BITS-1:0]  edge_q, edge_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             irq_q, irq_d;

   logic [2:0]       chan;
   logic [1:0]       rsel;
   logic [WIDTH-1:0] wval;
   logic [BITS-1:0]  w1c;
   logic [BITS-1:0]  det;
   logic             unused_wdata;

   assign chan         = avs_address[4:2];
   assign rsel         = avs_address[1:0];
   assign wval         = avs_writedata[WIDTH-1:0];
   assign unused_wdata = ^avs_writedata;

   always_comb begin
      sync1_d = gpio_in_port;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   always_comb begin
      det = '0;
      case (EDGE_MODE)
         0:       det = sync2_q & ~prev_q;
         1:       det = ~sync2_q & prev_q;
         default: det = sync2_q ^ prev_q;
      endcase
   end

   // A fresh detection wins over a same-cycle write-1-to-clear.
   always_comb begin
      out_d  = out_q;
      mask_d = mask_q;
      w1c    = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (avs_write && int'(chan) == c) begin
            case (rsel)
               2'd1:    out_d[c*WIDTH +: WIDTH]  = wval;
               2'd2:    mask_d[c*WIDTH +: WIDTH] = wval;
               2'd3:    w1c[c*WIDTH +: WIDTH]    = wval;
               default: ;
            endcase
         end
      end
      edge_d = (edge_q & ~w1c) | det;
      irq_d  = |(edge_q & mask_q);
   end

   always_comb begin
      rdata_d = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (avs_read && int'(chan) == c) begin
            case (rsel)
               2'd0:    rdata_d[WIDTH-1:0] = sync2_q[c*WIDTH +: WIDTH];
               2'd1:    rdata_d[WIDTH-1:0] = out_q[c*WIDTH +: WIDTH];
               2'd2:    rdata_d[WIDTH-1:0] = mask_q[c*WIDTH +: WIDTH];
               default: rdata_d[WIDTH-1:0] = edge_q[c*WIDTH +: WIDTH];
            endcase
         end
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         out_q   <= '0;
         mask_q  <= '0;
         edge_q  <= '0;
         rdata_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         out_q   <= out_d;
         mask_q  <= mask_d;
         edge_q  <= edge_d;
         rdata_q <= rdata_d;
         irq_q   <= irq_d;
      end
   end

   assign avs_readdata  = rdata_q;
   assign gpio_out_port = out_q;
   assign irq           = irq_q;

endmodule
